// File: rtl/wb8_wb32_bridge.sv
// Bridges an 8-bit Wishbone responder port onto a 32-bit big-endian Wishbone
// initiator, with an optional one-word read buffer that serves repeated byte reads.
module wb8_wb32_bridge #(
  parameter int ENABLE_BUFFER = 1
) (
  input  logic        clk,
  input  logic        reset,
  // 8-bit responder side
  input  logic [0:23] s_adr_i,
  input  logic [0:7]  s_dat_i,
  output logic [0:7]  s_dat_o,
  input  logic        s_we_i,
  input  logic [0:0]  s_sel_i,
  input  logic        s_stb_i,
  input  logic        s_cyc_i,
  output logic        s_ack_o,
  // 32-bit initiator side
  output logic [0:21] m_adr_o,
  output logic [0:31] m_dat_o,
  input  logic [0:31] m_dat_i,
  output logic        m_we_o,
  output logic [0:3]  m_sel_o,
  output logic        m_stb_o,
  output logic        m_cyc_o,
  input  logic        m_ack_i,
  // buffer invalidate pulse
  input  logic        inval_i
);

  typedef enum logic [1:0] {IDLE, BUS, ACK} state_t;

  state_t      state;
  logic        buf_valid;
  logic [0:21] buf_tag;
  logic [0:31] buf_data;
  logic [1:0]  lane_q;
  logic        we_q;
  logic        aborted;

  logic req;
  logic hit;

  assign req = s_cyc_i && s_stb_i && !s_ack_o;
  assign hit = (ENABLE_BUFFER != 0) && buf_valid && (buf_tag == s_adr_i[0:21]) && !s_we_i;

  // Lane 0 is the most significant byte of the 32-bit word.
  function automatic logic [0:7] lane_byte(input logic [0:31] w, input logic [1:0] l);
    case (l)
      2'd0:    lane_byte = w[0:7];
      2'd1:    lane_byte = w[8:15];
      2'd2:    lane_byte = w[16:23];
      default: lane_byte = w[24:31];
    endcase
  endfunction

  // NOTE: non-blocking assignments throughout so every register samples the
  // pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: buf_data/buf_tag are storage gated by buf_valid, so they are
      // deliberately left out of reset; clearing the valid flag is enough.
      state     <= IDLE;
      buf_valid <= 1'b0;
      s_ack_o   <= 1'b0;
      s_dat_o   <= '0;
      m_cyc_o   <= 1'b0;
      m_stb_o   <= 1'b0;
      m_we_o    <= 1'b0;
      m_sel_o   <= 4'b0000;
      m_adr_o   <= '0;
      m_dat_o   <= '0;
      lane_q    <= 2'd0;
      we_q      <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            lane_q <= s_adr_i[22:23];
            if (hit) begin
              s_dat_o <= lane_byte(buf_data, s_adr_i[22:23]);
              s_ack_o <= 1'b1;
              state   <= ACK;
            end else if (s_we_i && !s_sel_i[0]) begin
              s_ack_o <= 1'b1;
              state   <= ACK;
            end else begin
              m_adr_o <= s_adr_i[0:21];
              m_dat_o <= {4{s_dat_i}};
              m_we_o  <= s_we_i;
              m_sel_o <= s_we_i ? (4'b1000 >> s_adr_i[22:23]) : 4'b1111;
              m_cyc_o <= 1'b1;
              m_stb_o <= 1'b1;
              we_q    <= s_we_i;
              aborted <= 1'b0;
              state   <= BUS;
            end
          end
        end

        BUS: begin
          // An abandoned 8-bit cycle still lets the 32-bit cycle finish.
          if (!s_cyc_i) aborted <= 1'b1;
          if (m_ack_i) begin
            m_cyc_o <= 1'b0;
            m_stb_o <= 1'b0;
            if (!we_q) begin
              buf_data  <= m_dat_i;
              buf_tag   <= m_adr_o;
              buf_valid <= 1'b1;
              s_dat_o   <= lane_byte(m_dat_i, lane_q);
            end else if (buf_valid && (buf_tag == m_adr_o)) begin
              case (lane_q)
                2'd0:    buf_data[0:7]   <= m_dat_o[0:7];
                2'd1:    buf_data[8:15]  <= m_dat_o[0:7];
                2'd2:    buf_data[16:23] <= m_dat_o[0:7];
                default: buf_data[24:31] <= m_dat_o[0:7];
              endcase
            end
            if (aborted || !s_cyc_i) begin
              state <= IDLE;
            end else begin
              s_ack_o <= 1'b1;
              state   <= ACK;
            end
          end
        end

        ACK: begin
          s_ack_o <= 1'b0;
          state   <= IDLE;
        end

        default: state <= IDLE;
      endcase

      // Placed last so an invalidate overrides a same-cycle buffer fill.
      if (inval_i) buf_valid <= 1'b0;
    end
  end

endmodule
